// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - start/data/stop serial frame receiver with registered outputs
module serial_frame_rx #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              ser_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              frame_err,
    output logic              busy
);

    // Counter only needs to reach DATA_W-1; it is cleared on leaving DATA so it never wraps.
    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [DATA_W-1:0]  sr, sr_nxt;
    logic [DATA_W-1:0]  data_out_nxt;
    logic               data_valid_nxt;
    logic               frame_err_nxt;

    // State, datapath and output registers; busy is registered from the next state so it tracks state exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sr         <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sr         <= sr_nxt;
            data_out   <= data_out_nxt;
            data_valid <= data_valid_nxt;
            frame_err  <= frame_err_nxt;
            busy       <= (state_nxt != IDLE);
        end
    end

    // Next-state and next-output logic; everything holds unless a bit strobe arrives.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        sr_nxt         = sr;
        data_out_nxt   = data_out;
        data_valid_nxt = 1'b0;
        frame_err_nxt  = 1'b0;
        if (bit_en) begin
            case (state)
                IDLE: begin
                    if (!ser_in) begin
                        state_nxt = DATA;
                        cnt_nxt   = '0;
                    end
                end
                DATA: begin
                    // LSB arrives first, so shifting in at the top leaves it at bit 0 after DATA_W samples.
                    sr_nxt = {ser_in, sr[DATA_W-1:1]};
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        state_nxt = STOP;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    state_nxt = IDLE;
                    if (ser_in) begin
                        data_out_nxt   = sr;
                        data_valid_nxt = 1'b1;
                    end else begin
                        frame_err_nxt = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - scoreboard bench for serial_frame_rx
module tb_serial_frame_rx;

    localparam int DATA_W = 4;

    typedef struct {
        logic              err;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              bit_en = 1'b0;
    logic              ser_in = 1'b1;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              frame_err;
    logic              busy;

    int                checks = 0;
    int                failures = 0;
    exp_t              exp_q[$];
    logic [DATA_W-1:0] last_good = '0;

    serial_frame_rx #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en),
        .ser_in     (ser_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ser_in = b;
        bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
    endtask

    // Idle cycles with the strobe low; the line is scrambled to show it is ignored.
    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            bit_en = 1'b0;
            ser_in = 1'($urandom);
            tick();
        end
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] word, input logic stop_bit, input int g);
        exp_t e;
        send_bit(1'b0);
        check("busy_after_start", busy, 1);
        gap(g);
        for (int i = 0; i < DATA_W; i++) begin
            send_bit(word[i]);
            gap(g);
        end
        if (stop_bit) last_good = word;
        e.err  = ~stop_bit;
        e.data = last_good;
        exp_q.push_back(e);
        send_bit(stop_bit);
        check("busy_at_pulse", busy, 0);
        gap(g);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        bit_en = 1'b1;
        ser_in = 1'b0;
        for (int i = 0; i < n; i++) tick();
        rst = 1'b0;
        bit_en = 1'b0;
        ser_in = 1'b1;
        last_good = '0;
    endtask

    // Any pulse must match the oldest expected event; a pulse with nothing expected is an error.
    always @(negedge clk) begin
        if (data_valid === 1'b1 || frame_err === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {data_valid, frame_err}, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_kind", {data_valid, frame_err}, e.err ? 2'b01 : 2'b10);
                check("data_out", data_out, e.data);
            end
        end
    end

    initial begin
        do_reset(2);
        check("rst_data_out", data_out, 0);
        check("rst_valid", data_valid, 0);
        check("rst_err", frame_err, 0);
        check("rst_busy", busy, 0);

        send_frame(4'b1010, 1'b1, 0);
        check("f1_data_out", data_out, 4'b1010);
        gap(1);
        check("f1_valid_drop", data_valid, 0);

        send_frame(4'b1111, 1'b0, 0);
        gap(2);
        check("bad_stop_hold", data_out, 4'b1010);

        send_frame(4'b0111, 1'b1, 3);
        gap(4);
        check("slow_data_out", data_out, 4'b0111);

        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check("midframe_busy", busy, 1);
        do_reset(1);
        check("abort_busy", busy, 0);
        check("abort_data_out", data_out, 0);
        gap(3);
        send_frame(4'b1100, 1'b1, 0);
        gap(2);
        check("after_abort_data_out", data_out, 4'b1100);

        for (int i = 0; i < 10; i++) begin
            ser_in = 1'b1;
            bit_en = 1'b1;
            tick();
            check("idle_busy", busy, 0);
        end
        bit_en = 1'b0;

        send_frame(4'b0110, 1'b1, 0);
        send_frame(4'b1001, 1'b1, 0);
        gap(3);
        check("b2b_data_out", data_out, 4'b1001);
        check("pending_events", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
